// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
// Contents: receive FSM state type, data-bit count, idle line level.
package ps2_pkg;

    localparam int   PS2_DATA_BITS  = 8;
    localparam logic PS2_IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through byte FIFO for the PS/2 receiver.
// Ports:
//   clk, reset        clock, async active-high reset
//   push, push_data   write request and byte
//   pop               read request (ignored while empty)
//   pop_data          head byte, 0 while empty
//   valid             FIFO not empty
//   overflow          one-cycle pulse, push refused because full with no pop
//   level             current occupancy
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PS2_DATA_BITS-1:0] push_data,
    input  logic                     pop,
    output logic [PS2_DATA_BITS-1:0] pop_data,
    output logic                     valid,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [PS2_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic                     full;
    logic                     do_push;
    logic                     do_pop;

    assign valid    = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign pop_data = valid ? mem[rd_ptr] : '0;
    assign level    = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and filters the PS/2 lines,
// decodes 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// queues good bytes in a FIFO.
// Ports:
//   clk, reset             clock, async active-high reset
//   ps2_clk, ps2_data      raw PS/2 lines (asynchronous, idle high)
//   rx_data, rx_valid      FIFO head byte / not empty
//   rx_ready               consumer accept, pops when rx_valid is high
//   rx_err_parity          pulse, frame dropped for parity error
//   rx_err_frame           pulse, frame dropped for bad stop bit or timeout
//   rx_overflow            pulse, good byte dropped because FIFO full
//   fifo_level             FIFO occupancy
// Optional feature: define PS2_RX_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYC cycles without a falling ps2_clk edge.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for a start bit (fall with data low)
// ST_DATA   | shifting in the 8 data bits, LSB first
// ST_PARITY | checking odd parity against the data bits
// ST_STOP   | checking stop bit, pushing byte or flagging error
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          rx_err_parity,
    output logic                          rx_err_frame,
    output logic                          rx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic       clk_s1, clk_s2, dat_s1, dat_s2;
    logic       clk_filt, clk_filt_d;
    logic [3:0] filt_cnt;
    logic       fall;
    logic       timeout;

    ps2_state_t               state, state_n;
    logic [2:0]               bit_cnt, bit_cnt_n;
    logic [PS2_DATA_BITS-1:0] shift_reg, shift_n;
    logic                     par_err, par_err_n;
    logic                     push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1 <= PS2_IDLE_LEVEL;
            clk_s2 <= PS2_IDLE_LEVEL;
            dat_s1 <= PS2_IDLE_LEVEL;
            dat_s2 <= PS2_IDLE_LEVEL;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered level flips only once FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_filt   <= PS2_IDLE_LEVEL;
            clk_filt_d <= PS2_IDLE_LEVEL;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == 4'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_filt_d && !clk_filt;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (fall || state == ST_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires exactly TIMEOUT_CYC cycles after the last fall event.
    assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    localparam int timeout_unused = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_err   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            par_err   <= par_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift_reg;
        par_err_n     = par_err;
        push          = 1'b0;
        rx_err_parity = 1'b0;
        rx_err_frame  = 1'b0;
        if (timeout) begin
            state_n      = ST_IDLE;
            rx_err_frame = 1'b1;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!dat_s2) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                        par_err_n = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_n   = {dat_s2, shift_reg[PS2_DATA_BITS-1:1]};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_err_n = ~(^{shift_reg, dat_s2});
                    state_n   = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (par_err)     rx_err_parity = 1'b1;
                    else if (dat_s2) push          = 1'b1;
                    else             rx_err_frame  = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .valid     (rx_valid),
        .overflow  (rx_overflow),
        .level     (fifo_level)
    );

endmodule
